// File: rtl/yj_basic_pkg.sv
// yj_basic_pkg
// Shared definitions for the yj_basic CDC handshake blocks: FSM state
// encoding and the timeout counter width.
package yj_basic_pkg;

  localparam logic ST_IDLE     = 1'b0;
  localparam logic ST_WAIT_ACK = 1'b1;

  localparam int unsigned CDC_TO_W = 16;

  typedef enum logic {
    IDLE     = ST_IDLE,
    WAIT_ACK = ST_WAIT_ACK
  } cdc_tx_state_t;

endpackage : yj_basic_pkg

// File: rtl/yj_basic_ack_sync.sv
// yj_basic_ack_sync
// Single-bit flop-chain synchronizer. Used on tx_ack by the transmitter and
// reusable on tx_req by the far-side receiver.
// Ports:
//   CLK - destination-domain clock
//   RST - asynchronous active-high reset (chain clears to 0)
//   d   - asynchronous input level
//   q   - synchronized level, SYNC_STAGES edges after d settles
module yj_basic_ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous level through the chain; bit 0 is the metastable stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule : yj_basic_ack_sync

// File: rtl/yj_basic_cdc_handshake_tx.sv
// yj_basic_cdc_handshake_tx
// Transmit side of a toggle request/acknowledge clock-domain crossing. Takes
// one word from a valid/ready source, holds it on tx_data and toggles tx_req,
// then waits for tx_ack (synchronized locally) to match tx_req before taking
// the next word. At most one word is in flight.
// Optional feature: define YJ_BASIC_CDC_TX_TIMEOUT_EN to add the TIMEOUT
// parameter, a saturating wait counter and the sticky timeout_err output.
// Ports:
//   CLK         - sending-domain clock
//   RST         - asynchronous active-high reset
//   in_valid    - source has a word on in_data
//   in_ready    - block can accept a word this cycle (from registers only)
//   in_data     - word to transfer
//   tx_req      - request toggle level to the far domain
//   tx_data     - held data word, stable while busy
//   tx_ack      - acknowledge toggle from the far domain (asynchronous)
//   busy        - transfer outstanding
//   timeout_err - sticky wait timeout flag (macro builds only)
module yj_basic_cdc_handshake_tx
  import yj_basic_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2
`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT     = 255
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          tx_req,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ack,
  output logic          busy
`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  cdc_tx_state_t state;
  cdc_tx_state_t state_nxt;
  logic          ack_s;
  logic          accept;

  // Bring the far-domain acknowledge into CLK.
  yj_basic_ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (tx_ack),
    .q   (ack_s)
  );

  // A mismatched ack in IDLE (spurious toggle) also blocks acceptance.
  assign in_ready = (state == IDLE) && (ack_s == tx_req);
  assign busy     = (state == WAIT_ACK);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and accept strobe.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && (ack_s == tx_req)) begin
          accept    = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == tx_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Launch register: data and request change only on accept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_req  <= 1'b0;
      tx_data <= '0;
    end else if (accept) begin
      tx_req  <= ~tx_req;
      tx_data <= in_data;
    end
  end

`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
  logic [CDC_TO_W-1:0] to_cnt;
  logic [CDC_TO_W-1:0] to_cnt_inc;

  assign to_cnt_inc = (to_cnt == '1) ? to_cnt : to_cnt + CDC_TO_W'(1);

  // Count cycles spent waiting; the flag is sticky and never aborts the wait.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (state == WAIT_ACK) begin
      to_cnt <= to_cnt_inc;
      if (to_cnt_inc >= CDC_TO_W'(TIMEOUT)) begin
        timeout_err <= 1'b1;
      end
    end
  end
`endif

endmodule : yj_basic_cdc_handshake_tx

// File: tb/tb_yj_basic_cdc_handshake_tx.sv
// tb_yj_basic_cdc_handshake_tx
// Self-checking bench: directed reset/single/spurious/reset-mid-transfer/
// back-to-back cases, then randomized traffic with a far-side responder.
// Timeout cases are built only with YJ_BASIC_CDC_TX_TIMEOUT_EN.
module tb_yj_basic_cdc_handshake_tx;

  localparam int unsigned DW   = 32;
  localparam int unsigned SYNC = 2;
`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
  localparam int unsigned TO   = 8;
`endif

  logic          CLK;
  logic          RST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          tx_ack;
  logic          busy;
`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
  logic          timeout_err;
`endif

  yj_basic_cdc_handshake_tx #(
    .DW          (DW),
    .SYNC_STAGES (SYNC)
`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
    ,
    .TIMEOUT     (TO)
`endif
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_ack      (tx_ack),
    .busy        (busy)
`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk;
  int n_fail;

  // Reference model: transfer-level view plus a delay line for the ack path.
  bit            m_req;
  bit            m_busy;
  bit            m_acc;
  logic [DW-1:0] m_data;
  bit            ack_hist[$];
  int unsigned   m_wait;
  bit            m_err;

  // Words accepted by the transmitter, in order, awaiting the far side.
  logic [DW-1:0] sent[$];
  bit            auto_ack;
  bit            ack_pend;
  int unsigned   ack_dly;
  int            n_rx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_req  = 1'b0;
    m_busy = 1'b0;
    m_acc  = 1'b0;
    m_data = '0;
    m_wait = 0;
    m_err  = 1'b0;
    ack_hist.delete();
    for (int i = 0; i < SYNC; i++) ack_hist.push_back(1'b0);
  endfunction

  function automatic bit exp_ready();
    return !m_busy && (ack_hist[SYNC-1] == m_req);
  endfunction

  // One rising edge of the reference: the ack seen locally is tx_ack delayed SYNC edges.
  function automatic void model_step();
    bit ack_s;
    ack_s = ack_hist[SYNC-1];
    m_acc = (in_valid === 1'b1) && !m_busy && (ack_s == m_req);
    if (m_acc) begin
      m_req  = !m_req;
      m_data = in_data;
      m_busy = 1'b1;
      m_wait = 0;
      sent.push_back(in_data);
    end else if (m_busy) begin
      if (m_wait < 65535) m_wait++;
`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
      if (m_wait >= TO) m_err = 1'b1;
`endif
      if (ack_s == m_req) m_busy = 1'b0;
    end
    ack_hist.push_front(tx_ack === 1'b1);
    void'(ack_hist.pop_back());
  endfunction

  task automatic check_outputs();
    chk("in_ready", in_ready, exp_ready());
    chk("tx_req",   tx_req,   m_req);
    chk("tx_data",  tx_data,  m_data);
    chk("busy",     busy,     m_busy);
`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
    chk("timeout_err", timeout_err, m_err);
`endif
  endtask

  // Far-side receiver: sees a new request, waits a random time, checks data, returns the toggle.
  task automatic far_side();
    if (!auto_ack) return;
    if (!ack_pend) begin
      if (tx_req !== tx_ack) begin
        ack_pend = 1'b1;
        ack_dly  = $urandom_range(0, 3);
      end
    end else if (ack_dly != 0) begin
      ack_dly--;
    end else begin
      chk("rx_avail", sent.size() != 0, 1'b1);
      if (sent.size() != 0) chk("rx_data", tx_data, sent.pop_front());
      n_rx++;
      tx_ack   = tx_req;
      ack_pend = 1'b0;
    end
  endtask

  // Advance one cycle: reference updates at the edge, outputs checked at the falling edge.
  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset();
    else     model_step();
    @(negedge CLK);
    check_outputs();
    far_side();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sent.size() == 0 && !ack_pend) break;
      tick();
    end
    chk("drain_empty", sent.size(), 0);
  endtask

  bit exp_req[3];
  int idx;
  int lat;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    n_rx     = 0;
    auto_ack = 1'b0;
    ack_pend = 1'b0;
    RST      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tx_ack   = 1'b0;
    model_reset();

    // Reset and release.
    tick();
    tick();
    RST = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy",     busy,     1'b0);

    // Single word with a directed acknowledge.
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    tick();
    chk("single_req",  tx_req,  1'b1);
    chk("single_data", tx_data, 32'hDEADBEEF);
    chk("single_busy", busy,    1'b1);
    in_valid = 1'b0;
    tx_ack   = 1'b1;
    lat      = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (busy === 1'b0) break;
    end
    chk("release_latency", lat, SYNC + 1);
    chk("single_ready", in_ready, 1'b1);
    sent.delete();

    // Spurious ack toggle in IDLE: no launch, ready low until it matches again.
    tx_ack = 1'b0;
    for (int i = 0; i < SYNC + 2; i++) tick();
    chk("spur_ready_low", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) tick();
    chk("spur_no_launch", busy, 1'b0);
    chk("spur_req_held", tx_req, 1'b1);
    in_valid = 1'b0;
    tx_ack   = 1'b1;
    for (int i = 0; i < SYNC + 1; i++) tick();
    chk("spur_ready_back", in_ready, 1'b1);

    // Reset in the middle of a transfer clears outputs without a clock edge.
    in_valid = 1'b1;
    in_data  = 32'hA5A5_5A5A;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    RST    = 1'b1;
    tx_ack = 1'b0;
    #1;
    chk("arst_tx_req",   tx_req,   1'b0);
    chk("arst_tx_data",  tx_data,  '0);
    chk("arst_busy",     busy,     1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
    chk("arst_timeout", timeout_err, 1'b0);
`endif
    model_reset();
    sent.delete();
    ack_pend = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Back-to-back words with the source holding valid.
    auto_ack   = 1'b1;
    exp_req[0] = 1'b1;
    exp_req[1] = 1'b0;
    exp_req[2] = 1'b1;
    idx        = 0;
    in_valid   = 1'b1;
    in_data    = 32'h1;
    for (int i = 0; i < 100; i++) begin
      if (idx >= 3) break;
      tick();
      if (m_acc) begin
        chk("b2b_req", tx_req, exp_req[idx]);
        idx++;
        if (idx < 3) in_data = DW'(idx + 1);
        else         in_valid = 1'b0;
      end
    end
    chk("b2b_count", idx, 3);
    drain();

    // Randomized traffic; in_data changes every cycle, including while waiting.
    n_rx = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom();
      tick();
    end
    drain();
    chk("rand_progress", n_rx > 20, 1'b1);

`ifdef YJ_BASIC_CDC_TX_TIMEOUT_EN
    // Never acknowledge: flag rises after TO waiting cycles and stays.
    auto_ack = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h7777_0001;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_not_yet", timeout_err, 1'b0);
    tick();
    chk("to_set", timeout_err, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    tx_ack = m_req;
    for (int i = 0; i < SYNC + 2; i++) tick();
    chk("to_released", busy, 1'b0);
    chk("to_sticky", timeout_err, 1'b1);
    sent.delete();
    RST    = 1'b1;
    tx_ack = 1'b0;
    #1;
    chk("to_cleared", timeout_err, 1'b0);
    model_reset();
    tick();
    @(negedge CLK);
    RST = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_yj_basic_cdc_handshake_tx
